image_pair_packer: RTL and testbench

// Consumes the dual-pixel RGB stream of the image read path (data_write + two RGB pixels/clock) and

---
 rtl/image_pair_packer.sv | 133 +++++++++++++
 tb/tb_image_pair_packer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/image_pair_packer.sv
// Packs dual-pixel RGB pairs into BGR words and writes them bottom-up into frame memory
// through a 4-entry show-ahead FIFO. Handshake: an entry transfers on any edge where mem_we & mem_ready.
module image_pair_packer #(
  parameter int WIDTH  = 768,
  parameter int HEIGHT = 512,
  parameter int ADDR_W = 18
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              data_write,
  input  logic [7:0]        DATA_R0,
  input  logic [7:0]        DATA_G0,
  input  logic [7:0]        DATA_B0,
  input  logic [7:0]        DATA_R1,
  input  logic [7:0]        DATA_G1,
  input  logic [7:0]        DATA_B1,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [47:0]       mem_wdata,
  input  logic              mem_ready,
  output logic              Write_Done,
  output logic              overflow,
  output logic [1:0]        state_dbg
);

  localparam int PAIRS = WIDTH / 2;
  localparam int COL_W = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int ENT_W = ADDR_W + 48;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [ENT_W-1:0] fifo_mem [4];
  logic [1:0]       wr_ptr;
  logic [1:0]       rd_ptr;
  logic [2:0]       count;

  logic              full;
  logic              pop;
  logic              push;
  logic              drop;
  logic              restart;
  logic              last_pair;
  logic [COL_W-1:0]  cur_col;
  logic [ROW_W-1:0]  cur_row;
  logic [ADDR_W-1:0] push_addr;
  logic [47:0]       push_data;
  logic [2:0]        count_next;

  assign mem_we    = (count != 3'd0);
  assign mem_addr  = fifo_mem[rd_ptr][ENT_W-1:48];
  assign mem_wdata = fifo_mem[rd_ptr][47:0];
  assign state_dbg = state;

  always_comb begin
    full      = (count == 3'd4);
    pop       = mem_we & mem_ready;
    restart   = (state == IDLE) || (state == DONE);
    // A full FIFO still accepts when its head leaves on the same edge.
    push      = data_write && (state != DRAIN) && (!full || pop);
    drop      = data_write && !push;
    cur_col   = restart ? '0 : col;
    cur_row   = restart ? '0 : row;
    last_pair = (int'(cur_row) == HEIGHT - 1) && (int'(cur_col) == PAIRS - 1);
    push_addr = ADDR_W'((HEIGHT - 1 - int'(cur_row)) * PAIRS + int'(cur_col));
    push_data = {DATA_R1, DATA_G1, DATA_B1, DATA_R0, DATA_G0, DATA_B0};
    case ({push, pop})
      2'b10:   count_next = count + 3'd1;
      2'b01:   count_next = count - 3'd1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      Write_Done <= 1'b0;
      overflow   <= 1'b0;
      for (int i = 0; i < 4; i++) fifo_mem[i] <= '0;
    end else begin
      count <= count_next;
      if (push) begin
        fifo_mem[wr_ptr] <= {push_addr, push_data};
        wr_ptr           <= wr_ptr + 2'd1;
        if (int'(cur_col) == PAIRS - 1) begin
          col <= '0;
          row <= cur_row + 1'b1;
        end else begin
          col <= cur_col + 1'b1;
          row <= cur_row;
        end
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      if (drop) overflow <= 1'b1;

      case (state)
        IDLE: begin
          if (push) state <= last_pair ? DRAIN : RUN;
        end
        RUN: begin
          if (push && last_pair) state <= DRAIN;
        end
        DRAIN: begin
          if (count_next == 3'd0) begin
            state      <= DONE;
            Write_Done <= 1'b1;
          end
        end
        DONE: begin
          if (push) begin
            Write_Done <= 1'b0;
            state      <= last_pair ? DRAIN : RUN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_image_pair_packer.sv
// Randomized and directed checks of image_pair_packer against a queue-based model of
// the frame order, bottom-up addressing, buffering, drops and completion flag.
module tb_image_pair_packer;

  localparam int WIDTH  = 6;
  localparam int HEIGHT = 3;
  localparam int ADDR_W = 5;
  localparam int PAIRS  = WIDTH / 2;
  localparam int TOTAL  = PAIRS * HEIGHT;
  localparam int ENT_W  = ADDR_W + 48;

  logic              HCLK = 1'b0;
  logic              HRESET = 1'b1;
  logic              data_write = 1'b0;
  logic [7:0]        DATA_R0 = '0, DATA_G0 = '0, DATA_B0 = '0;
  logic [7:0]        DATA_R1 = '0, DATA_G1 = '0, DATA_B1 = '0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [47:0]       mem_wdata;
  logic              mem_ready = 1'b0;
  logic              Write_Done;
  logic              overflow;
  logic [1:0]        state_dbg;

  image_pair_packer #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .ADDR_W(ADDR_W)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .data_write(data_write),
    .DATA_R0(DATA_R0), .DATA_G0(DATA_G0), .DATA_B0(DATA_B0),
    .DATA_R1(DATA_R1), .DATA_G1(DATA_G1), .DATA_B1(DATA_B1),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .Write_Done(Write_Done), .overflow(overflow),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 HCLK = ~HCLK;

  // reference model state
  logic [ENT_W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int m_n;
  bit m_idle, m_drain, m_done, m_ovf;

  function automatic logic [ADDR_W-1:0] pair_addr(input int k);
    int r, c;
    r = k / PAIRS;
    c = k % PAIRS;
    return ADDR_W'((HEIGHT - 1 - r) * PAIRS + c);
  endfunction

  function automatic logic [63:0] model_state();
    if (m_idle) return 64'd0;
    if (m_drain) return 64'd2;
    if (m_done) return 64'd3;
    return 64'd1;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_outputs();
    logic [ENT_W-1:0] head;
    check("mem_we", 64'(mem_we), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      head = exp_q[0];
      check("mem_addr", 64'(mem_addr), 64'(head[ENT_W-1:48]));
      check("mem_wdata", 64'(mem_wdata), 64'(head[47:0]));
    end
    check("write_done", 64'(Write_Done), 64'(m_done));
    check("overflow", 64'(overflow), 64'(m_ovf));
    check("state", 64'(state_dbg), model_state());
    check("done_while_we", 64'(Write_Done & mem_we), 64'd0);
  endtask

  // driver: check current outputs, apply one cycle of inputs, advance model
  task automatic step(input bit dw, input bit rdy,
                      input logic [7:0] r0, input logic [7:0] g0, input logic [7:0] b0,
                      input logic [7:0] r1, input logic [7:0] g1, input logic [7:0] b1);
    bit pop;
    int pre;
    compare_outputs();
    data_write = dw;
    mem_ready  = rdy;
    DATA_R0 = r0; DATA_G0 = g0; DATA_B0 = b0;
    DATA_R1 = r1; DATA_G1 = g1; DATA_B1 = b1;
    pre = exp_q.size();
    pop = (pre != 0) && rdy;
    if (pop) void'(exp_q.pop_front());
    if (m_drain) begin
      if (dw) m_ovf = 1'b1;
      if (exp_q.size() == 0) begin
        m_drain = 1'b0;
        m_done  = 1'b1;
      end
    end else if (dw) begin
      if (m_idle || m_done) begin
        m_n    = 0;
        m_idle = 1'b0;
        m_done = 1'b0;
      end
      if (pre < 4 || pop) begin
        exp_q.push_back({pair_addr(m_n), r1, g1, b1, r0, g0, b0});
        m_n++;
        if (m_n == TOTAL) m_drain = 1'b1;
      end else begin
        m_ovf = 1'b1;
      end
    end
    @(posedge HCLK);
    @(negedge HCLK);
  endtask

  task automatic rstep(input bit dw, input bit rdy);
    step(dw, rdy, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
         8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
         8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
  endtask

  task automatic do_reset();
    HRESET     = 1'b1;
    data_write = 1'b0;
    mem_ready  = 1'b0;
    @(posedge HCLK);
    @(negedge HCLK);
    HRESET = 1'b0;
    exp_q.delete();
    m_n     = 0;
    m_idle  = 1'b1;
    m_drain = 1'b0;
    m_done  = 1'b0;
    m_ovf   = 1'b0;
  endtask

  initial begin
    // full frame, memory always ready
    do_reset();
    check("rst_we", 64'(mem_we), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_wdata", 64'(mem_wdata), 64'd0);
    check("rst_done", 64'(Write_Done), 64'd0);
    check("rst_state", 64'(state_dbg), 64'd0);
    for (int k = 0; k < TOTAL; k++) rstep(1'b1, 1'b1);
    repeat (3) rstep(1'b0, 1'b1);
    check("t1_done", 64'(Write_Done), 64'd1);
    check("t1_ovf", 64'(overflow), 64'd0);

    // restart from DONE with a known pair, then finish the second frame
    step(1'b1, 1'b0, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66);
    check("t2_wdata", 64'(mem_wdata), 64'h0000_4455_6611_2233);
    check("t2_byte0", 64'(mem_wdata[7:0]), 64'h33);
    check("t2_addr", 64'((HEIGHT - 1) * PAIRS), 64'(mem_addr));
    check("t6_done_drop", 64'(Write_Done), 64'd0);
    for (int k = 1; k < TOTAL; k++) rstep(1'b1, 1'b1);
    repeat (3) rstep(1'b0, 1'b1);
    check("t6_done", 64'(Write_Done), 64'd1);

    // stalled memory: 4 buffered, 2 dropped, then drain in order
    do_reset();
    repeat (6) rstep(1'b1, 1'b0);
    check("t3_ovf", 64'(overflow), 64'd1);
    repeat (5) rstep(1'b0, 1'b1);
    for (int k = 4; k < TOTAL; k++) rstep(1'b1, 1'b1);
    repeat (3) rstep(1'b0, 1'b1);
    check("t3_done", 64'(Write_Done), 64'd1);

    // full FIFO with simultaneous pop accepts the push
    do_reset();
    repeat (4) rstep(1'b1, 1'b0);
    rstep(1'b1, 1'b1);
    check("t4_ovf", 64'(overflow), 64'd0);
    check("t4_we", 64'(mem_we), 64'd1);
    repeat (6) rstep(1'b0, 1'b1);

    // reset mid-frame with entries buffered
    do_reset();
    repeat (3) rstep(1'b1, 1'b0);
    do_reset();
    check("t5_we", 64'(mem_we), 64'd0);
    check("t5_done", 64'(Write_Done), 64'd0);
    check("t5_state", 64'(state_dbg), 64'd0);
    rstep(1'b1, 1'b1);
    check("t5_addr", 64'(mem_addr), 64'((HEIGHT - 1) * PAIRS));

    // randomized traffic across several frames
    for (int i = 0; i < 3000; i++)
      rstep($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 60);
    repeat (8) rstep(1'b0, 1'b1);
    compare_outputs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
